// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry accumulator slice: FSM state
// encoding and the default datapath width.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } rca_state_e;

  localparam int RCA_WIDTH = 4;

endpackage

// File: rtl/rca_nbit.sv
// Parameterised ripple-carry adder: a plain chain of full adders,
// purely combinational.
module rca_nbit #(
  parameter int WIDTH = rca_pkg::RCA_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = c_in;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]      = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1]  = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign c_out = carry[WIDTH];

endmodule

// File: rtl/rca_accumulator.sv
// Batch accumulator around rca_nbit: takes NUM_OPS operands over a
// valid/ready stream, sums them with a sticky carry-out flag and presents
// the result on a valid/ready output.
// Optional build macro RCA_ACC_SATURATE_EN: clamp the accumulator to
// all-ones whenever an addition carries out (default: wrap mod 2^WIDTH).
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// ACCUM | accepting operands, one per transfer
// DONE  | result presented until out_ready
module rca_accumulator
  import rca_pkg::*;
#(
  parameter int WIDTH   = RCA_WIDTH,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(NUM_OPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  rca_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cin_q, cin_d;

  logic [WIDTH-1:0] add_s;
  logic             add_co;
  logic [WIDTH-1:0] acc_next;
  logic             xfer;

  rca_nbit #(.WIDTH(WIDTH)) u_rca (
    .x     (acc_q),
    .y     (in_data),
    .c_in  (cin_q),
    .sum   (add_s),
    .c_out (add_co)
  );

  // Operand transfer: ready is decoded from state, not registered.
  assign xfer = in_valid && (state_q == ACCUM);

  // Value loaded into acc on a transfer; saturating builds clamp on carry.
  always_comb begin
`ifdef RCA_ACC_SATURATE_EN
    acc_next = add_co ? {WIDTH{1'b1}} : add_s;
`else
    acc_next = add_s;
`endif
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (xfer && (cnt_q == LAST_CNT)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: clear on accepted start, accumulate on each transfer.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    cin_d = cin_q;
    if ((state_q == IDLE) && start) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
      cin_d = c_in;
    end else if (xfer) begin
      acc_d = acc_next;
      ovf_d = ovf_q | add_co;
      cnt_d = cnt_q + CNT_W'(1);
      cin_d = 1'b0;
    end
  end

  // Outputs decoded from state; result fields read zero outside DONE.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    busy      = (state_q == ACCUM) || (state_q == DONE);
    out_sum   = (state_q == DONE) ? acc_q : '0;
    out_ovf   = (state_q == DONE) ? ovf_q : 1'b0;
  end

endmodule

// File: tb/tb_rca_accumulator.sv
// Self-checking bench for rca_accumulator: directed vector table, reset
// abort, start/out_ready corner cases, a NUM_OPS=1 instance and random
// batches checked against an arithmetic reference model.
module tb_rca_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, c_in, in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf, busy;
  logic [3:0] out_sum;

  logic       s1_start, s1_c_in, s1_in_valid, s1_out_ready;
  logic [3:0] s1_in_data;
  logic       s1_in_ready, s1_out_valid, s1_out_ovf, s1_busy;
  logic [3:0] s1_out_sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_accumulator #(.WIDTH(4), .NUM_OPS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  rca_accumulator #(.WIDTH(4), .NUM_OPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .c_in(s1_c_in),
    .in_valid(s1_in_valid), .in_data(s1_in_data), .in_ready(s1_in_ready),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_sum(s1_out_sum),
    .out_ovf(s1_out_ovf), .busy(s1_busy)
  );

  typedef struct {
    logic             ci;
    logic [3:0][3:0]  ops;
    logic [3:0][2:0]  gaps;
    int               stall;
    logic             start_in_done;
    logic [3:0]       exp_sum;
    logic             exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Whole-batch arithmetic: total = c_in + sum of operands. Any carry-out
  // in the chain happens exactly when total reaches 2^WIDTH.
  function automatic void ref_model(input logic ci, input logic [3:0][3:0] ops,
                                    output logic [3:0] s, output logic o);
    int total;
    total = int'(ci);
    for (int i = 0; i < 4; i++) total += int'(ops[i]);
    o = (total >= 16);
`ifdef RCA_ACC_SATURATE_EN
    s = o ? 4'hF : 4'(total);
`else
    s = 4'(total % 16);
`endif
  endfunction

  // One batch on the NUM_OPS=4 instance; entered and left at a negedge in IDLE.
  task automatic run_batch(input string tag, input vec_t v);
    int budget;
    start = 1'b1; c_in = v.ci;
    @(negedge clk);
    start = 1'b0; c_in = 1'b0;
    chk({tag, " busy_accum"}, 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < int'(v.gaps[i]); g++) begin
        in_valid = 1'b0; in_data = 4'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " gap_no_valid"}, 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1; in_data = v.ops[i];
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 3) chk({tag, " early_valid"}, 32'(out_valid), 32'd0);
    end
    chk({tag, " latency"}, 32'(out_valid), 32'd1);
    budget = 8;
    while (!out_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!out_valid) chk({tag, " timeout"}, 32'(out_valid), 32'd1);
    chk({tag, " sum"}, 32'(out_sum), 32'(v.exp_sum));
    chk({tag, " ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    out_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " stall_sum"}, 32'(out_sum), 32'(v.exp_sum));
      chk({tag, " stall_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
    end
    out_ready = 1'b1; start = v.start_in_done;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk({tag, " post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " post_busy"}, 32'(busy), 32'd0);
    chk({tag, " post_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " post_sum"}, 32'(out_sum), 32'd0);
    if (v.start_in_done) begin
      repeat (3) @(negedge clk);
      chk({tag, " no_restart"}, 32'(busy), 32'd0);
    end
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    rst_n = 1'b0; start = 0; c_in = 0; in_valid = 0; in_data = 0; out_ready = 0;
    s1_start = 0; s1_c_in = 0; s1_in_valid = 0; s1_in_data = 0; s1_out_ready = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{1'b0, {4'd4, 4'd3, 4'd2, 4'd1}, '0, 0, 1'b0, 4'b1010, 1'b0};
`ifdef RCA_ACC_SATURATE_EN
    tbl[1] = '{1'b1, {4'hF, 4'hF, 4'hF, 4'hF}, '0, 0, 1'b0, 4'b1111, 1'b1};
    tbl[2] = '{1'b0, {4'd0, 4'd0, 4'd8, 4'd8}, '0, 1, 1'b0, 4'hF, 1'b1};
`else
    tbl[1] = '{1'b1, {4'hF, 4'hF, 4'hF, 4'hF}, '0, 0, 1'b0, 4'b1101, 1'b1};
    tbl[2] = '{1'b0, {4'd0, 4'd0, 4'd8, 4'd8}, '0, 1, 1'b0, 4'h0, 1'b1};
`endif
    // operands 4,5,6,7 with valid pattern 1,0,0,1,0,1,1 and a 5-cycle stall
    tbl[3] = '{1'b0, {4'd7, 4'd6, 4'd5, 4'd4}, {3'd0, 3'd1, 3'd2, 3'd0}, 5, 1'b0, 4'd6, 1'b1};
    tbl[4] = '{1'b1, {4'd0, 4'd0, 4'd0, 4'd0}, '0, 0, 1'b1, 4'd1, 1'b0};
    tbl[5] = '{1'b0, {4'd0, 4'd5, 4'd5, 4'd5}, '0, 2, 1'b0, 4'd15, 1'b0};
`ifdef RCA_ACC_SATURATE_EN
    tbl[3].exp_sum = 4'hF;
`endif

    for (int i = 0; i < 6; i++) run_batch($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset in the middle of an ACCUM batch.
    start = 1'b1; c_in = 1'b1;
    @(negedge clk);
    start = 1'b0; c_in = 1'b0;
    in_valid = 1'b1; in_data = 4'd9;
    @(negedge clk);
    in_data = 4'd9;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    chk("abort_out_ovf", 32'(out_ovf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run_batch("after_abort", tbl[0]);

    // NUM_OPS=1 instance.
    s1_start = 1'b1; s1_c_in = 1'b1;
    @(negedge clk);
    s1_start = 1'b0; s1_c_in = 1'b0;
    s1_in_valid = 1'b1; s1_in_data = 4'b0111;
    chk("n1_in_ready", 32'(s1_in_ready), 32'd1);
    @(negedge clk);
    s1_in_valid = 1'b0;
    chk("n1_valid", 32'(s1_out_valid), 32'd1);
    chk("n1_sum", 32'(s1_out_sum), 32'b1000);
    chk("n1_ovf", 32'(s1_out_ovf), 32'd0);
    s1_out_ready = 1'b1;
    @(negedge clk);
    s1_out_ready = 1'b0;
    chk("n1_post_valid", 32'(s1_out_valid), 32'd0);
    s1_start = 1'b1; s1_c_in = 1'b1;
    @(negedge clk);
    s1_start = 1'b0; s1_c_in = 1'b0;
    s1_in_valid = 1'b1; s1_in_data = 4'hF;
    @(negedge clk);
    s1_in_valid = 1'b0;
`ifdef RCA_ACC_SATURATE_EN
    chk("n1_carry_sum", 32'(s1_out_sum), 32'hF);
`else
    chk("n1_carry_sum", 32'(s1_out_sum), 32'h0);
`endif
    chk("n1_carry_ovf", 32'(s1_out_ovf), 32'd1);
    s1_out_ready = 1'b1;
    @(negedge clk);
    s1_out_ready = 1'b0;

    // Random batches against the arithmetic model.
    for (int n = 0; n < 25; n++) begin
      rv.ci = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        rv.ops[i]  = 4'($urandom_range(0, 15));
        rv.gaps[i] = 3'($urandom_range(0, 2));
      end
      rv.stall = $urandom_range(0, 3);
      rv.start_in_done = 1'b0;
      ref_model(rv.ci, rv.ops, rv.exp_sum, rv.exp_ovf);
      run_batch($sformatf("rnd%0d", n), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
